// File: rtl/level_sensor_conditioner.sv
// Synchronises, debounces and plausibility-checks the lower (I) and upper (S) tank level sensors.
// Fault detection is built only when LEVEL_SENSOR_FAULT_EN is defined.
module level_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FAULT_CYCLES    = 16
) (
    input  logic inputClk,
    input  logic inputReset,
    input  logic inputIRaw,
    input  logic inputSRaw,
    input  logic inputFaultClear,
    output logic outputI,
    output logic outputS,
    output logic outputFault
);

    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);

    // Channel index 0 carries I, index 1 carries S.
    logic [1:0]          raw_w;
    logic [1:0]          s1_q;
    logic [1:0]          s2_q;
    logic [1:0]          f_q;
    logic [1:0]          f_d;
    logic [1:0][DCW-1:0] dbc_q;
    logic [1:0][DCW-1:0] dbc_d;

    assign raw_w = {inputSRaw, inputIRaw};

    always_comb begin
        f_d   = f_q;
        dbc_d = '0;
        for (int ch = 0; ch < 2; ch++) begin
            if (s2_q[ch] != f_q[ch]) begin
                if (dbc_q[ch] == DB_LAST) begin
                    f_d[ch] = s2_q[ch];
                end else begin
                    dbc_d[ch] = dbc_q[ch] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge inputClk) begin
        if (inputReset) begin
            s1_q  <= '0;
            s2_q  <= '0;
            f_q   <= '0;
            dbc_q <= '0;
        end else begin
            s1_q  <= raw_w;
            s2_q  <= s1_q;
            f_q   <= f_d;
            dbc_q <= dbc_d;
        end
    end

`ifdef LEVEL_SENSOR_FAULT_EN
    localparam int FCW = $clog2(FAULT_CYCLES + 1);
    localparam logic [FCW-1:0] FC_LAST = FCW'(FAULT_CYCLES - 1);

    logic           implaus_w;
    logic [FCW-1:0] fc_q;
    logic [FCW-1:0] fc_d;
    logic           fault_q;
    logic           fault_d;

    // Upper sensor wet while lower is dry cannot happen in a real tank.
    assign implaus_w = f_q[1] & ~f_q[0];

    always_comb begin
        fc_d    = fc_q;
        fault_d = fault_q;
        if (!implaus_w) begin
            fc_d = '0;
            if (inputFaultClear) begin
                fault_d = 1'b0;
            end
        end else if (fc_q == FC_LAST) begin
            fault_d = 1'b1;
        end else begin
            fc_d = fc_q + 1'b1;
        end
    end

    always_ff @(posedge inputClk) begin
        if (inputReset) begin
            fc_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            fc_q    <= fc_d;
            fault_q <= fault_d;
        end
    end

    // A fault reports "tank full" so the pump controller shuts both pumps off.
    assign outputFault = fault_q;
    assign outputI     = f_q[0] | fault_q;
    assign outputS     = f_q[1] | fault_q;
`else
    localparam int unused_fault_cycles = FAULT_CYCLES;
    logic unused_clear_w;

    assign unused_clear_w = inputFaultClear;
    assign outputFault    = 1'b0;
    assign outputI        = f_q[0];
    assign outputS        = f_q[1];
`endif

endmodule

// File: tb/tb_level_sensor_conditioner.sv
// Directed vector bench for level_sensor_conditioner (defaults plus a DEBOUNCE_CYCLES=1 instance).
module tb_level_sensor_conditioner;

`ifdef LEVEL_SENSOR_FAULT_EN
    localparam logic FEN = 1'b1;
`else
    localparam logic FEN = 1'b0;
`endif

    typedef struct {
        logic rst;
        logic iraw;
        logic sraw;
        logic clr;
        logic ei;
        logic es;
        logic ef;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic iraw = 1'b0;
    logic sraw = 1'b0;
    logic clr = 1'b0;
    logic o_i0, o_s0, o_f0;
    logic o_i1, o_s1, o_f1;

    int n_cmp = 0;
    int n_fail = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    level_sensor_conditioner u_dut (
        .inputClk(clk), .inputReset(rst), .inputIRaw(iraw), .inputSRaw(sraw),
        .inputFaultClear(clr), .outputI(o_i0), .outputS(o_s0), .outputFault(o_f0)
    );

    level_sensor_conditioner #(.DEBOUNCE_CYCLES(1), .FAULT_CYCLES(2)) u_dut1 (
        .inputClk(clk), .inputReset(rst), .inputIRaw(iraw), .inputSRaw(sraw),
        .inputFaultClear(clr), .outputI(o_i1), .outputS(o_s1), .outputFault(o_f1)
    );

    function automatic void add(input logic r, input logic i, input logic s, input logic c,
                                input logic ei, input logic es, input logic ef);
        vec_t v;
        v.rst = r; v.iraw = i; v.sraw = s; v.clr = c;
        v.ei = ei; v.es = es; v.ef = ef;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] got=%b expected=%b", nm, idx, act, exp);
        end
    endtask

    task automatic run(input int sel);
        for (int k = 0; k < vq.size(); k++) begin
            rst  = vq[k].rst;
            iraw = vq[k].iraw;
            sraw = vq[k].sraw;
            clr  = vq[k].clr;
            @(posedge clk);
            #1;
            if (sel == 0) begin
                chk("d4_outputI", k, o_i0, vq[k].ei);
                chk("d4_outputS", k, o_s0, vq[k].es);
                chk("d4_outputFault", k, o_f0, vq[k].ef);
            end else begin
                chk("d1_outputI", k, o_i1, vq[k].ei);
                chk("d1_outputS", k, o_s1, vq[k].es);
                chk("d1_outputFault", k, o_f1, vq[k].ef);
            end
        end
        vq.delete();
    endtask

    initial begin
        logic ef;
        // Reset, then raw I held: outputI rises on edge 6.
        add(1, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 6; k++) add(0, 1, 0, 0, logic'(k == 6), 0, 0);
        // 3-cycle S glitch is filtered out.
        for (int k = 1; k <= 9; k++) add(0, 1, logic'(k <= 3), 0, 1, 0, 0);
        // 4-cycle S pulse passes: rises edge 6, falls edge 10 (6 after raw fall).
        for (int k = 1; k <= 12; k++) add(0, 1, logic'(k <= 4), 0, 1, logic'(k >= 6 && k <= 9), 0);
        // Implausible S=1, I=0: fS at edge 6, fault 16 edges later at edge 22.
        add(1, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 26; k++) begin
            ef = FEN & logic'(k >= 22);
            add(0, 0, 1, 0, ef, logic'(k >= 6) | ef, ef);
        end
        // Clear while implausible is ignored.
        add(0, 0, 1, 1, FEN, 1, FEN);
        // S released and filter settled; fault stays latched.
        for (int k = 1; k <= 8; k++) add(0, 0, 0, 0, FEN, FEN | logic'(k < 6), FEN);
        add(0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        // Re-latch fault, start an I debounce up to count 2, then reset with clear and P.
        add(1, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 22; k++) begin
            ef = FEN & logic'(k >= 22);
            add(0, 0, 1, 0, ef, logic'(k >= 6) | ef, ef);
        end
        for (int k = 1; k <= 4; k++) add(0, 1, 1, 0, FEN, 1, FEN);
        add(1, 1, 1, 1, 0, 0, 0);
        for (int k = 1; k <= 6; k++) add(0, 1, 1, 0, logic'(k == 6), logic'(k == 6), 0);
        run(0);

        // DEBOUNCE_CYCLES=1: 3-edge latency; FAULT_CYCLES=2: fault 2 edges after P.
        add(1, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) add(0, 1, 0, 0, logic'(k >= 3), 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            ef = FEN & logic'(k >= 5);
            add(0, 0, 1, 0, ef, logic'(k >= 3), ef);
        end
        run(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
